// File: rtl/twpm_wb_pkg.sv
// Shared constants for the TwPM Wishbone interconnect: slave indices, FSM
// state encoding, default address windows and the window-match helper.
package twpm_wb_pkg;

  localparam int NUM_SLV = 4;

  localparam logic [1:0] SLV_REGS   = 2'd0;
  localparam logic [1:0] SLV_TPMRAM = 2'd1;
  localparam logic [1:0] SLV_DDR    = 2'd2;
  localparam logic [1:0] SLV_CTRL   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [31:0] DEF_REGS_BASE   = 32'hF000_0000;
  localparam int          DEF_REGS_AW     = 11;
  localparam logic [31:0] DEF_TPMRAM_BASE = 32'hF000_0800;
  localparam int          DEF_TPMRAM_AW   = 11;
  localparam logic [31:0] DEF_CTRL_BASE   = 32'hF800_0000;
  localparam int          DEF_CTRL_AW     = 14;
  localparam logic [31:0] DEF_DDR_BASE    = 32'h8000_0000;
  localparam int          DEF_DDR_AW      = 27;

  // A window matches when every address bit above its width equals the base.
  function automatic logic win_hit(input logic [31:0] adr, input logic [31:0] base,
                                   input int aw);
    return (adr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/twpm_wb_addr_decoder.sv
// Combinational address decoder: maps a request address to a slave index.
// Windows are checked in a fixed order and the first match wins.
module twpm_wb_addr_decoder
  import twpm_wb_pkg::*;
#(
  parameter logic [31:0] REGS_BASE   = DEF_REGS_BASE,
  parameter int          REGS_AW     = DEF_REGS_AW,
  parameter logic [31:0] TPMRAM_BASE = DEF_TPMRAM_BASE,
  parameter int          TPMRAM_AW   = DEF_TPMRAM_AW,
  parameter logic [31:0] CTRL_BASE   = DEF_CTRL_BASE,
  parameter int          CTRL_AW     = DEF_CTRL_AW,
  parameter logic [31:0] DDR_BASE    = DEF_DDR_BASE,
  parameter int          DDR_AW      = DEF_DDR_AW
) (
  input  logic [31:0] adr_i,
  output logic        hit_o,
  output logic [1:0]  idx_o
);

  always_comb begin
    hit_o = 1'b1;
    idx_o = SLV_REGS;
    if (win_hit(adr_i, REGS_BASE, REGS_AW)) begin
      idx_o = SLV_REGS;
    end else if (win_hit(adr_i, TPMRAM_BASE, TPMRAM_AW)) begin
      idx_o = SLV_TPMRAM;
    end else if (win_hit(adr_i, CTRL_BASE, CTRL_AW)) begin
      idx_o = SLV_CTRL;
    end else if (win_hit(adr_i, DDR_BASE, DDR_AW)) begin
      idx_o = SLV_DDR;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/twpm_wb_interconnect.sv
// Single-master Wishbone interconnect in front of the TwPM slaves, with
// registered responses, unmapped-address error, timeout and error capture.
module twpm_wb_interconnect
  import twpm_wb_pkg::*;
#(
  parameter logic [31:0] REGS_BASE          = DEF_REGS_BASE,
  parameter int          REGS_AW            = DEF_REGS_AW,
  parameter logic [31:0] TPMRAM_BASE        = DEF_TPMRAM_BASE,
  parameter int          TPMRAM_AW          = DEF_TPMRAM_AW,
  parameter logic [31:0] CTRL_BASE          = DEF_CTRL_BASE,
  parameter int          CTRL_AW            = DEF_CTRL_AW,
  parameter logic [31:0] DDR_BASE           = DEF_DDR_BASE,
  parameter int          DDR_AW             = DEF_DDR_AW,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter logic [31:0] DEFAULT_READ_VALUE = 32'hBADF_ABAC
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  m_adr_i,
  input  logic [31:0]  m_dat_i,
  input  logic [3:0]   m_sel_i,
  input  logic         m_we_i,
  input  logic         m_stb_i,
  input  logic         m_cyc_i,
  output logic [31:0]  m_dat_o,
  output logic         m_ack_o,
  output logic         m_err_o,
  output logic [31:0]  s_adr_o,
  output logic [31:0]  s_dat_o,
  output logic [3:0]   s_sel_o,
  output logic         s_we_o,
  output logic         s_cyc_o,
  output logic [3:0]   s_stb_o,
  input  logic [3:0]   s_ack_i,
  input  logic [3:0]   s_err_i,
  input  logic [127:0] s_dat_i,
  output logic         timeout_o,
  output logic [31:0]  err_adr_o,
  output logic [7:0]   err_cnt_o
);

  localparam int          CNT_W     = 16;
  localparam logic [15:0] TIMEOUT_V = CNT_W'(TIMEOUT_CYCLES);

  logic       dec_hit;
  logic [1:0] dec_idx;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic        timeout_q, timeout_d;
  logic [31:0] err_adr_q, err_adr_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        fail;
  logic [31:0] fail_adr;

  twpm_wb_addr_decoder #(
    .REGS_BASE   (REGS_BASE),
    .REGS_AW     (REGS_AW),
    .TPMRAM_BASE (TPMRAM_BASE),
    .TPMRAM_AW   (TPMRAM_AW),
    .CTRL_BASE   (CTRL_BASE),
    .CTRL_AW     (CTRL_AW),
    .DDR_BASE    (DDR_BASE),
    .DDR_AW      (DDR_AW)
  ) u_decoder (
    .adr_i (m_adr_i),
    .hit_o (dec_hit),
    .idx_o (dec_idx)
  );

  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;
  assign s_we_o  = m_we_i;
  assign s_cyc_o = m_cyc_i;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    err_adr_d = err_adr_q;
    err_cnt_d = err_cnt_q;
    fail      = 1'b0;
    fail_adr  = adr_q;
    s_stb_o   = '0;

    case (state_q)
      ST_IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          adr_d = m_adr_i;
          if (dec_hit) begin
            idx_d   = dec_idx;
            cnt_d   = '0;
            state_d = ST_ACTIVE;
          end else begin
            fail     = 1'b1;
            fail_adr = m_adr_i;
            state_d  = ST_RESP;
          end
        end
      end
      ST_ACTIVE: begin
        s_stb_o[idx_q] = m_stb_i;
        cnt_d          = cnt_q + 16'd1;
        // A slave response in the timeout cycle still wins over the timeout.
        if (!m_cyc_i) begin
          state_d = ST_IDLE;
        end else if (s_err_i[idx_q]) begin
          fail    = 1'b1;
          state_d = ST_RESP;
        end else if (s_ack_i[idx_q]) begin
          ack_d   = 1'b1;
          dat_d   = s_dat_i[{idx_q, 5'd0} +: 32];
          state_d = ST_RESP;
        end else if (cnt_q == TIMEOUT_V) begin
          fail      = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      err_d     = 1'b1;
      dat_d     = DEFAULT_READ_VALUE;
      err_adr_d = fail_adr;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    if (rst_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= SLV_REGS;
      cnt_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      timeout_q <= timeout_d;
      err_adr_q <= err_adr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_dat_o   = dat_q;
  assign m_ack_o   = ack_q;
  assign m_err_o   = err_q;
  assign timeout_o = timeout_q;
  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: doc/twpm_wb_interconnect.md
# twpm_wb_interconnect

Single-master Wishbone interconnect placed directly downstream of the NEORV32 CPU's external bus, in front of the TwPM slaves: TPM registers, TPM command/response RAM, LiteDRAM user port and LiteDRAM controller CSRs. It decodes each classic-cycle request to exactly one slave and gates that slave's strobe. It returns the selected slave's read data, ack and err to the CPU through registered outputs. It also adds an unmapped-address error, a per-transaction timeout and bus-error capture, so a hung or missing slave cannot stall the CPU forever.

## Interface
Parameters:
- `REGS_BASE`, 32'hF0000000: TPM register window base; `REGS_AW`, 11: window address width.
- `TPMRAM_BASE`, 32'hF0000800; `TPMRAM_AW`, 11.
- `CTRL_BASE`, 32'hF8000000; `CTRL_AW`, 14.
- `DDR_BASE`, 32'h80000000; `DDR_AW`, 27.
- `TIMEOUT_CYCLES`, 255: number of ACTIVE cycles before the block forces an error. Range 1..65535.
- `DEFAULT_READ_VALUE`, 32'hBADFABAC: value returned on `m_dat_o` with any error response.

Ports (clock and reset first):
- `clk_i` in 1: bus clock, same clock as the CPU.
- `rst_i` in 1: reset, synchronous, active-high.
- `m_adr_i` in 32, `m_dat_i` in 32, `m_sel_i` in 4, `m_we_i` in 1, `m_stb_i` in 1, `m_cyc_i` in 1: master request.
- `m_dat_o` out 32, `m_ack_o` out 1, `m_err_o` out 1: master response.
- `s_adr_o` out 32, `s_dat_o` out 32, `s_sel_o` out 4, `s_we_o` out 1, `s_cyc_o` out 1: shared slave request. These are combinational copies of the master request.
- `s_stb_o` out 4: one-hot per-slave strobe. Index 0 = REGS, 1 = TPMRAM, 2 = DDR, 3 = CTRL.
- `s_ack_i` in 4, `s_err_i` in 4: per-slave response.
- `s_dat_i` in 128: per-slave read data. Slave n drives bits [32n+31:32n].
- `timeout_o` out 1: one-cycle pulse when a timeout fires.
- `err_adr_o` out 32: address of the most recent error.
- `err_cnt_o` out 8: saturating error count.

## Operation
- The FSM has three states: IDLE, ACTIVE and RESP.
- IDLE:
  - When `m_cyc_i & m_stb_i` and the address decodes to a slave: latch the slave index, clear the timeout counter, go to ACTIVE.
  - When `m_cyc_i & m_stb_i` and the address matches no window: go to RESP with the error flag set.
- ACTIVE:
  - `s_stb_o[idx] = m_stb_i`. All other strobe bits are 0.
  - The counter increments once per ACTIVE cycle.
  - Response selection, highest priority first:
    1. `m_cyc_i` low: abort. Return to IDLE with no response.
    2. `s_err_i[idx]`: go to RESP with error.
    3. `s_ack_i[idx]`: capture `s_dat_i[idx]` and go to RESP with ack.
    4. Counter equals `TIMEOUT_CYCLES`: go to RESP with error and pulse `timeout_o`.
  - A slave ack or err arriving in the same cycle as the timeout wins over the timeout.
- RESP:
  - Drive `m_ack_o` or `m_err_o` for exactly one cycle. Never both at once.
  - On error, `m_dat_o = DEFAULT_READ_VALUE`; on ack, `m_dat_o` carries the captured data.
  - Return to IDLE unconditionally.
- Address decode:
  - A window matches when `m_adr_i[31:AW] == BASE[31:AW]`.
  - Check order is REGS, TPMRAM, CTRL, DDR. The first match wins.
- Error capture: each error response loads `err_adr_o` with the request address and increments `err_cnt_o`, which saturates at 255.
- Responses from slaves other than the selected one, and responses arriving outside ACTIVE, are ignored.

## Timing
- Reset values: FSM in IDLE; `m_ack_o` = 0, `m_err_o` = 0, `m_dat_o` = 0, `s_stb_o` = 0, `timeout_o` = 0, `err_adr_o` = 0, `err_cnt_o` = 0, counter = 0.
- Reset asserted mid-transaction takes precedence over everything. No response is issued for the interrupted transaction.
- Mapped access, counting from cycle 0 (request seen in IDLE):
  - `s_stb_o` asserts from cycle 1.
  - A slave ack sampled at cycle k produces `m_ack_o` at cycle k+1.
  - Minimum latency is 2 cycles (slave acks in cycle 1).
- Unmapped access: request at cycle 0, `m_err_o` at cycle 1.
- Timeout: `m_err_o` appears `TIMEOUT_CYCLES`+1 cycles after entering ACTIVE. `timeout_o` pulses in the same cycle as `m_err_o`.
- Back-to-back: a new request can be accepted in the cycle after RESP. Minimum spacing is 3 cycles per mapped transaction.
- Abort: `s_stb_o` falls combinationally with `m_stb_i`. The FSM is back in IDLE on the next edge.

## Structure
- Package `twpm_wb_pkg` holds:
  - slave index constants (`SLV_REGS`, `SLV_TPMRAM`, `SLV_DDR`, `SLV_CTRL`, `NUM_SLV`);
  - the state encoding;
  - the default window base and width constants, shared with the top level.
- Sub-module `twpm_wb_addr_decoder`: purely combinational. It maps `m_adr_i` to a hit flag and a 2-bit slave index.
- The FSM, timeout counter, response registers and error capture live in the parent module.

## Test plan
- Read 0xF0000004; REGS acks at cycle 1 with 0x5 → `m_ack_o` at cycle 2, `m_dat_o`=0x5, `s_stb_o`=4'b0001.
- Write 0x80000100 with sel 4'b0011; DDR acks after 7 cycles → `s_stb_o`=4'b0100, `s_we_o`=1, single `m_ack_o`, `err_cnt_o` stays 0.
- Read 0x40000000 (unmapped) → `m_err_o` at cycle 1, `m_dat_o`=0xBADFABAC, `err_adr_o`=0x40000000, `err_cnt_o`=1.
- `TIMEOUT_CYCLES`=16, CTRL never responds → `m_err_o` and `timeout_o` 17 cycles after entering ACTIVE; CTRL ack at cycle 16 instead → `m_ack_o`, no timeout.
- Simultaneous `s_ack_i` and `s_err_i` from TPMRAM → only `m_err_o`. Ack from a non-selected slave → ignored.
- Drop `m_cyc_i` mid-ACTIVE, then send a late slave ack → no master response and FSM in IDLE. Assert `rst_i` mid-ACTIVE → all outputs 0 next cycle.
